spi_parity_frame_checker: RTL

- Parametrised successor of the single-bit SPI odd-parity tracker.
- Deserialises SPI frames of DATA_BITS data bits followed by one received parity bit, MSB first.
- Computes odd or even parity over the data bits, checks it against the received parity bit, and flags mismatches.
- Sits beside the SPI slave shift path. Consumes the same cs/sample/in strobes and reports per-frame status to the register block.

---
 rtl/spi_parity_frame_checker.sv | 87 ++++++++
 1 files changed

// File: rtl/spi_parity_frame_checker.sv
// spi_parity_frame_checker: deserialises SPI data+parity frames (MSB first), checks odd/even parity, reports per-frame status
//   i_clk, i_rst_n (async active-low), i_cs (active-low select), i_sample (bit strobe), i_in (serial bit)
//   o_parity_bit (running parity), o_frame_data, o_frame_valid, o_parity_err, o_frame_abort (pulses),
//   o_err_count (saturating parity-error count), o_busy (frame in progress)
module spi_parity_frame_checker #(
  parameter int DATA_BITS  = 8,
  parameter bit ODD_PARITY = 1'b1,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_cs,
  input  logic                 i_sample,
  input  logic                 i_in,
  output logic                 o_parity_bit,
  output logic [DATA_BITS-1:0] o_frame_data,
  output logic                 o_frame_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_abort,
  output logic [ERR_CNT_W-1:0] o_err_count,
  output logic                 o_busy
);
  localparam int CW = $clog2(DATA_BITS);
  typedef enum logic [1:0] {IDLE, ARMED, DATA, PAR} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [DATA_BITS-1:0] r_shift, r_frame_data;
  logic [ERR_CNT_W-1:0] r_err_count;
  logic r_parity, r_valid, r_err, r_abort;
  logic w_smp, w_in_frame, w_last;
  assign w_smp      = i_sample & ~i_cs;
  assign w_in_frame = (r_state == DATA) || (r_state == PAR);
  assign w_last     = r_cnt == CW'(DATA_BITS - 1);
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = i_cs ? ARMED : IDLE;
      ARMED:   w_next = i_cs ? ARMED : DATA;
      DATA:    w_next = i_cs ? ARMED : (i_sample && w_last) ? PAR : DATA;
      PAR:     w_next = i_cs ? ARMED : i_sample ? DATA : PAR;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt        <= '0;
      r_shift      <= '0;
      r_frame_data <= '0;
      r_err_count  <= '0;
      r_parity     <= ODD_PARITY;
      r_valid      <= 1'b0;
      r_err        <= 1'b0;
      r_abort      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_abort <= w_in_frame && i_cs;
      if (r_state == ARMED && !i_cs) begin
        r_cnt    <= '0;
        r_shift  <= '0;
        r_parity <= ODD_PARITY;
      end else if (r_state == DATA && w_smp) begin
        r_shift  <= {r_shift[DATA_BITS-2:0], i_in};
        r_parity <= r_parity ^ i_in;
        r_cnt    <= r_cnt + 1'b1;
      end else if (r_state == PAR && w_smp) begin
        r_valid      <= 1'b1;
        r_frame_data <= r_shift;
        r_err        <= i_in != r_parity;
        if (i_in != r_parity && !(&r_err_count)) r_err_count <= r_err_count + 1'b1;
        r_cnt    <= '0;
        r_shift  <= '0;
        r_parity <= ODD_PARITY;
      end
    end
  end
  assign o_parity_bit  = r_parity;
  assign o_frame_data  = r_frame_data;
  assign o_frame_valid = r_valid;
  assign o_parity_err  = r_err;
  assign o_frame_abort = r_abort;
  assign o_err_count   = r_err_count;
  assign o_busy        = w_in_frame;
endmodule
